// File: rtl/unique0_dr.sv
// JTAG data-register bank between the TAP controller and the AXI master of the JTAG-to-AXI bridge.
// Captures, shifts and updates the selected DR; TDO comes from negedge-retimed copies of the shift state.
module unique0_dr #(
    parameter logic [31:0] IDCODE_VAL   = 32'hBADC0FFE,
    parameter int          IC_RST_WIDTH = 4,
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32,
    parameter int          CTRL_W       = 16,
    parameter int          STATUS_W     = 40
) (
    input  logic                    tck,
    input  logic                    trstn,
    input  logic                    tdi,
    output logic                    tdo,
    input  logic [3:0]              tap_state,
    input  logic [3:0]              ir_dec,
    output logic [IC_RST_WIDTH-1:0] ic_rst,
    input  logic [STATUS_W-1:0]     jtag_status_i,
    output logic                    axi_status_rd_o,
    output logic [ADDR_W-1:0]       axi_addr_o,
    output logic [DATA_W-1:0]       axi_data_wr_o,
    output logic [CTRL_W-1:0]       axi_ctrl_o,
    output logic                    axi_req_new_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int SR_W = max2(max2(max2(ADDR_W, DATA_W), max2(CTRL_W, STATUS_W)), IC_RST_WIDTH);

    if (IC_RST_WIDTH > SR_W) begin : g_bad_ic_rst_width
        $error("IC_RST_WIDTH must not exceed the shared shift register width");
    end

    localparam logic [3:0] TAP_CAPTURE_DR = 4'h3;
    localparam logic [3:0] TAP_SHIFT_DR   = 4'h4;
    localparam logic [3:0] TAP_UPDATE_DR  = 4'h8;

    localparam logic [3:0] IR_SAMPLE   = 4'h1;
    localparam logic [3:0] IR_IDCODE   = 4'h3;
    localparam logic [3:0] IR_ADDR     = 4'h4;
    localparam logic [3:0] IR_DATA_W   = 4'h5;
    localparam logic [3:0] IR_CTRL     = 4'h6;
    localparam logic [3:0] IR_STATUS   = 4'h7;
    localparam logic [3:0] IR_IC_RESET = 4'hC;
    localparam logic [3:0] IR_BYPASS   = 4'hF;

    logic                    bypass_q,    bypass_d;
    logic [31:0]             idcode_q,    idcode_d;
    logic [SR_W-1:0]         sr_q,        sr_d;
    logic [ADDR_W-1:0]       addr_q,      addr_d;
    logic [DATA_W-1:0]       data_wr_q,   data_wr_d;
    logic [CTRL_W-1:0]       ctrl_q,      ctrl_d;
    logic [IC_RST_WIDTH-1:0] ic_rst_q,    ic_rst_d;
    logic                    req_new_q,   req_new_d;
    logic                    status_rd_q, status_rd_d;

    logic                    bypass_n_q;
    logic [31:0]             idcode_n_q;
    logic [SR_W-1:0]         sr_n_q;

    // NOTE: every _d is given its hold value first so no path through this block can infer a latch.
    always_comb begin
        bypass_d    = bypass_q;
        idcode_d    = idcode_q;
        sr_d        = sr_q;
        addr_d      = addr_q;
        data_wr_d   = data_wr_q;
        ctrl_d      = ctrl_q;
        ic_rst_d    = ic_rst_q;
        req_new_d   = 1'b0;
        status_rd_d = 1'b0;
        case (tap_state)
            TAP_CAPTURE_DR: begin
                case (ir_dec)
                    IR_BYPASS:   bypass_d = 1'b0;
                    IR_IDCODE:   idcode_d = IDCODE_VAL;
                    IR_SAMPLE:   sr_d     = '0;
                    IR_IC_RESET: sr_d[IC_RST_WIDTH-1:0] = ic_rst_q;
                    IR_ADDR:     sr_d[ADDR_W-1:0]       = addr_q;
                    IR_DATA_W:   sr_d[DATA_W-1:0]       = data_wr_q;
                    IR_CTRL:     sr_d[CTRL_W-1:0]       = ctrl_q;
                    IR_STATUS:   sr_d[STATUS_W-1:0]     = jtag_status_i;
                    default: ;
                endcase
            end
            TAP_SHIFT_DR: begin
                // Each DR shifts only its own low w bits; the rest of sr is left as is.
                case (ir_dec)
                    IR_BYPASS:   bypass_d = tdi;
                    IR_IDCODE:   idcode_d = {tdi, idcode_q[31:1]};
                    IR_SAMPLE:   sr_d     = {tdi, sr_q[SR_W-1:1]};
                    IR_IC_RESET: sr_d[IC_RST_WIDTH-1:0] = {tdi, sr_q[IC_RST_WIDTH-1:1]};
                    IR_ADDR:     sr_d[ADDR_W-1:0]       = {tdi, sr_q[ADDR_W-1:1]};
                    IR_DATA_W:   sr_d[DATA_W-1:0]       = {tdi, sr_q[DATA_W-1:1]};
                    IR_CTRL:     sr_d[CTRL_W-1:0]       = {tdi, sr_q[CTRL_W-1:1]};
                    IR_STATUS:   sr_d[STATUS_W-1:0]     = {tdi, sr_q[STATUS_W-1:1]};
                    default: ;
                endcase
            end
            TAP_UPDATE_DR: begin
                case (ir_dec)
                    IR_IC_RESET: ic_rst_d  = sr_q[IC_RST_WIDTH-1:0];
                    IR_ADDR:     addr_d    = sr_q[ADDR_W-1:0];
                    IR_DATA_W:   data_wr_d = sr_q[DATA_W-1:0];
                    IR_CTRL: begin
                        ctrl_d    = sr_q[CTRL_W-1:0];
                        req_new_d = 1'b1;
                    end
                    IR_STATUS:   status_rd_d = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge tck) begin
        if (!trstn) begin
            bypass_q    <= 1'b0;
            idcode_q    <= '0;
            sr_q        <= '0;
            addr_q      <= '0;
            data_wr_q   <= '0;
            ctrl_q      <= '0;
            ic_rst_q    <= '0;
            req_new_q   <= 1'b0;
            status_rd_q <= 1'b0;
        end else begin
            bypass_q    <= bypass_d;
            idcode_q    <= idcode_d;
            sr_q        <= sr_d;
            addr_q      <= addr_d;
            data_wr_q   <= data_wr_d;
            ctrl_q      <= ctrl_d;
            ic_rst_q    <= ic_rst_d;
            req_new_q   <= req_new_d;
            status_rd_q <= status_rd_d;
        end
    end

    // Half-cycle retime so TDO changes on the falling edge, as the TAP expects.
    always_ff @(negedge tck) begin
        if (!trstn) begin
            bypass_n_q <= 1'b0;
            idcode_n_q <= '0;
            sr_n_q     <= '0;
        end else begin
            bypass_n_q <= bypass_q;
            idcode_n_q <= idcode_q;
            sr_n_q     <= sr_q;
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (tap_state == TAP_SHIFT_DR) begin
            case (ir_dec)
                IR_BYPASS: tdo = bypass_n_q;
                IR_IDCODE: tdo = idcode_n_q[0];
                IR_SAMPLE, IR_IC_RESET, IR_ADDR, IR_DATA_W, IR_CTRL, IR_STATUS: tdo = sr_n_q[0];
                default: ;
            endcase
        end
    end

    assign ic_rst          = ic_rst_q;
    assign axi_addr_o      = addr_q;
    assign axi_data_wr_o   = data_wr_q;
    assign axi_ctrl_o      = ctrl_q;
    assign axi_req_new_o   = req_new_q;
    assign axi_status_rd_o = status_rd_q;

endmodule

// File: tb/tb_unique0_dr.sv
// Bench for unique0_dr: table of DR scan vectors with a TDO scoreboard, plus reset/hold sequences.
module tb_unique0_dr;

    localparam logic [3:0] TAP_IDLE = 4'h0, TAP_CAP = 4'h3, TAP_SHIFT = 4'h4, TAP_UPD = 4'h8;
    localparam logic [3:0] IR_SAMPLE = 4'h1, IR_IDCODE = 4'h3, IR_ADDR = 4'h4, IR_DATA = 4'h5;
    localparam logic [3:0] IR_CTRL = 4'h6, IR_STATUS = 4'h7, IR_IC = 4'hC, IR_BYPASS = 4'hF;

    logic        tck = 1'b0;
    logic        trstn = 1'b0;
    logic        tdi = 1'b0;
    logic        tdo;
    logic [3:0]  tap_state = TAP_IDLE;
    logic [3:0]  ir_dec = IR_BYPASS;
    logic [3:0]  ic_rst;
    logic [39:0] jtag_status_i = '0;
    logic        axi_status_rd_o;
    logic [31:0] axi_addr_o;
    logic [31:0] axi_data_wr_o;
    logic [15:0] axi_ctrl_o;
    logic        axi_req_new_o;

    unique0_dr dut (
        .tck            (tck),
        .trstn          (trstn),
        .tdi            (tdi),
        .tdo            (tdo),
        .tap_state      (tap_state),
        .ir_dec         (ir_dec),
        .ic_rst         (ic_rst),
        .jtag_status_i  (jtag_status_i),
        .axi_status_rd_o(axi_status_rd_o),
        .axi_addr_o     (axi_addr_o),
        .axi_data_wr_o  (axi_data_wr_o),
        .axi_ctrl_o     (axi_ctrl_o),
        .axi_req_new_o  (axi_req_new_o)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic [3:0]  ir;
        int          width;
        logic [63:0] din;
        logic [63:0] dout;
        logic [39:0] status;
    } vec_t;

    vec_t vecs[10];

    int n_pass  = 0;
    int n_total = 0;
    logic exp_q[$];

    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic [15:0] exp_ctrl = '0;
    logic [3:0]  exp_ic   = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        else
            n_pass++;
    endtask

    // One TCK cycle: inputs change just after the rising edge, return after the falling edge.
    task automatic drive(input logic [3:0] ts, input logic [3:0] ir, input logic d, input logic rn = 1'b1);
        @(posedge tck);
        #1;
        tap_state = ts;
        ir_dec    = ir;
        tdi       = d;
        trstn     = rn;
        #6;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_addr"}, 64'(axi_addr_o), 64'(exp_addr));
        check({tag, "_data"}, 64'(axi_data_wr_o), 64'(exp_data));
        check({tag, "_ctrl"}, 64'(axi_ctrl_o), 64'(exp_ctrl));
        check({tag, "_ic_rst"}, 64'(ic_rst), 64'(exp_ic));
    endtask

    task automatic shift_bits(input logic [3:0] ir, input int first, input int last,
                              input logic [63:0] din, input logic [63:0] dout);
        for (int i = first; i < last; i++) begin
            exp_q.push_back(dout[i]);
            drive(TAP_SHIFT, ir, din[i]);
            check($sformatf("tdo_ir%h_b%0d", ir, i), 64'(tdo), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic run_vec(input vec_t v);
        jtag_status_i = v.status;
        drive(TAP_CAP, v.ir, 1'b0);
        shift_bits(v.ir, 0, v.width, v.din, v.dout);
        drive(TAP_UPD, v.ir, 1'b0);
        case (v.ir)
            IR_IC:   exp_ic   = v.din[3:0];
            IR_ADDR: exp_addr = v.din[31:0];
            IR_DATA: exp_data = v.din[31:0];
            IR_CTRL: exp_ctrl = v.din[15:0];
            default: ;
        endcase
        drive(TAP_IDLE, v.ir, 1'b0);
        check($sformatf("req_pulse_ir%h", v.ir), 64'(axi_req_new_o), 64'(v.ir == IR_CTRL));
        check($sformatf("status_pulse_ir%h", v.ir), 64'(axi_status_rd_o), 64'(v.ir == IR_STATUS));
        check("idle_tdo", 64'(tdo), 64'd0);
        check_regs($sformatf("upd_ir%h", v.ir));
        drive(TAP_IDLE, v.ir, 1'b0);
        check("req_low_after", 64'(axi_req_new_o), 64'd0);
        check("status_low_after", 64'(axi_status_rd_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{IR_IDCODE, 32, 64'h0123_4567_89AB_CDEF, 64'hBADC_0FFE, 40'h0};
        vecs[1] = '{IR_BYPASS, 4,  64'hD,                  64'hA,          40'h0};
        vecs[2] = '{IR_IC,     4,  64'hA,                  64'h0,          40'h0};
        vecs[3] = '{IR_IC,     4,  64'h3,                  64'hA,          40'h0};
        vecs[4] = '{IR_ADDR,   32, 64'h8000_0010,          64'h0,          40'h0};
        vecs[5] = '{IR_CTRL,   16, 64'h0003,               64'h0,          40'h0};
        vecs[6] = '{IR_DATA,   32, 64'hDEAD_BEEF,          64'h0,          40'h0};
        vecs[7] = '{IR_ADDR,   32, 64'h1234_5678,          64'h8000_0010,  40'h0};
        vecs[8] = '{IR_STATUS, 40, 64'h0,                  64'hA5_1234_5678, 40'hA5_1234_5678};
        vecs[9] = '{IR_SAMPLE, 40, 64'hFF_FFFF_FFFF,       64'h0,          40'h0};

        // Reset held two cycles.
        drive(TAP_IDLE, IR_BYPASS, 1'b0, 1'b0);
        drive(TAP_IDLE, IR_BYPASS, 1'b0, 1'b0);
        check_regs("reset");
        check("reset_tdo", 64'(tdo), 64'd0);
        check("reset_req", 64'(axi_req_new_o), 64'd0);
        check("reset_status_rd", 64'(axi_status_rd_o), 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // CTRL UPDATE held three cycles: one pulse cycle per UPDATE cycle, register stable.
        drive(TAP_CAP, IR_CTRL, 1'b0);
        shift_bits(IR_CTRL, 0, 16, 64'h00A5, 64'h0003);
        exp_ctrl = 16'h00A5;
        drive(TAP_UPD, IR_CTRL, 1'b0);
        check("hold_u1_req", 64'(axi_req_new_o), 64'd0);
        drive(TAP_UPD, IR_CTRL, 1'b0);
        check("hold_u2_req", 64'(axi_req_new_o), 64'd1);
        drive(TAP_UPD, IR_CTRL, 1'b0);
        check("hold_u3_req", 64'(axi_req_new_o), 64'd1);
        check("hold_ctrl", 64'(axi_ctrl_o), 64'(exp_ctrl));
        drive(TAP_IDLE, IR_CTRL, 1'b0);
        check("hold_i1_req", 64'(axi_req_new_o), 64'd1);
        drive(TAP_IDLE, IR_CTRL, 1'b0);
        check("hold_i2_req", 64'(axi_req_new_o), 64'd0);
        check("hold_ctrl_after", 64'(axi_ctrl_o), 64'(exp_ctrl));

        // Reset in the middle of a STATUS shift clears everything; next capture reloads.
        jtag_status_i = 40'hA5_1234_5678;
        drive(TAP_CAP, IR_STATUS, 1'b0);
        shift_bits(IR_STATUS, 0, 5, 64'h0, 64'hA5_1234_5678);
        drive(TAP_SHIFT, IR_STATUS, 1'b0, 1'b0);
        check("midrst_tdo_a", 64'(tdo), 64'd0);
        drive(TAP_SHIFT, IR_STATUS, 1'b0);
        check("midrst_tdo_b", 64'(tdo), 64'd0);
        exp_addr = '0;
        exp_data = '0;
        exp_ctrl = '0;
        exp_ic   = '0;
        check_regs("midrst");
        shift_bits(IR_STATUS, 0, 6, 64'h0, 64'h0);
        run_vec(vecs[8]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
